alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes the 32-bit product A*B by repeatedly driving the shared combinational ALU with shift-and-add micro-ops (ADD, SLL, SRL).
- The ALU datapath has no multiplier and `*` is illegal, so this block supplies MUL for the core.
- Sits beside the ALU; the core's ALU input mux selects this block's operands while oAluReq is high.
- Valid/ready handshake on the request side and on the result side.

---
 rtl/alu_mul_sequencer_if.sv | 28 ++
 rtl/alu_mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Request/result handshake and shared-ALU port bundle for the shift-and-add multiplier.
// The sequencer takes the slave modport; the core/requester side takes master.
interface alu_mul_sequencer_if;
    logic        iValid;
    logic        oReady;
    logic [31:0] iDataA;
    logic [31:0] iDataB;
    logic        oValid;
    logic        iReady;
    logic [31:0] oResult;
    logic        oBusy;
    logic        oAluReq;
    logic [31:0] oAluA;
    logic [31:0] oAluB;
    logic [3:0]  oAluOp;
    logic [31:0] iAluResult;
    logic        iAluZero;

    modport slave (
        input  iValid, iDataA, iDataB, iReady, iAluResult, iAluZero,
        output oReady, oValid, oResult, oBusy, oAluReq, oAluA, oAluB, oAluOp
    );

    modport master (
        output iValid, iDataA, iDataB, iReady, iAluResult, iAluZero,
        input  oReady, oValid, oResult, oBusy, oAluReq, oAluA, oAluB, oAluOp
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 32x32->32 multiplier that drives the shared ALU with ADD/SLL/SRL micro-ops.
// All outputs are registered; ALU operands for a state are prepared on the edge entering it.
module alu_mul_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    alu_mul_sequencer_if.slave    bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b1001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  iter_q, iter_d;

    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [31:0] result_q, result_d;
    logic        alu_req_q, alu_req_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;

        case (state_q)
            IDLE: begin
                if (bus.iValid) begin
                    acc_d    = 32'd0;
                    mcand_d  = bus.iDataA;
                    mplier_d = bus.iDataB;
                    iter_d   = 6'd0;
                    if (EARLY_EXIT && (bus.iDataB == 32'd0)) state_d = DONE;
                    else if (bus.iDataB[0])                  state_d = ADD;
                    else                                     state_d = SHL;
                end
            end
            ADD: begin
                acc_d   = bus.iAluResult;
                state_d = SHL;
            end
            SHL: begin
                mcand_d = bus.iAluResult;
                state_d = SHR;
            end
            SHR: begin
                mplier_d = bus.iAluResult;
                iter_d   = iter_q + 6'd1;
                if ((EARLY_EXIT && bus.iAluZero) || (iter_q == 6'd31)) state_d = DONE;
                else if (bus.iAluResult[0])                              state_d = ADD;
                else                                                     state_d = SHL;
            end
            DONE: begin
                if (bus.iReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are a function of the state being entered and the register values it will see.
        ready_d   = (state_d == IDLE);
        valid_d   = (state_d == DONE);
        busy_d    = (state_d != IDLE);
        result_d  = (state_d == DONE) ? acc_d : 32'd0;
        alu_req_d = 1'b0;
        alu_a_d   = 32'd0;
        alu_b_d   = 32'd0;
        alu_op_d  = OP_ADD;
        case (state_d)
            ADD: begin
                alu_req_d = 1'b1;
                alu_a_d   = acc_d;
                alu_b_d   = mcand_d;
                alu_op_d  = OP_ADD;
            end
            SHL: begin
                alu_req_d = 1'b1;
                alu_a_d   = mcand_d;
                alu_b_d   = 32'd1;
                alu_op_d  = OP_SLL;
            end
            SHR: begin
                alu_req_d = 1'b1;
                alu_a_d   = mplier_d;
                alu_b_d   = 32'd1;
                alu_op_d  = OP_SRL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= IDLE;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            iter_q    <= 6'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= 32'd0;
            alu_req_q <= 1'b0;
            alu_a_q   <= 32'd0;
            alu_b_q   <= 32'd0;
            alu_op_q  <= OP_ADD;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            iter_q    <= iter_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            alu_req_q <= alu_req_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign bus.oReady  = ready_q;
    assign bus.oValid  = valid_q;
    assign bus.oBusy   = busy_q;
    assign bus.oResult = result_q;
    assign bus.oAluReq = alu_req_q;
    assign bus.oAluA   = alu_a_q;
    assign bus.oAluB   = alu_b_q;
    assign bus.oAluOp  = alu_op_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: directed vector table, handshake/reset corner sequences,
// and random products, with a behavioural ALU closing the operand loop.
module tb_alu_mul_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mul_sequencer_if bus0 ();
    alu_mul_sequencer_if bus1 ();

    alu_mul_sequencer #(.EARLY_EXIT(1'b1)) u_dut0 (.iClk(clk), .iRst(rst), .bus(bus0));
    alu_mul_sequencer #(.EARLY_EXIT(1'b0)) u_dut1 (.iClk(clk), .iRst(rst), .bus(bus1));

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: alu_f = a + b;
            4'b0001: alu_f = a << b[4:0];
            4'b1001: alu_f = a >> b[4:0];
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign bus0.iAluResult = alu_f(bus0.oAluOp, bus0.oAluA, bus0.oAluB);
    assign bus0.iAluZero   = (bus0.iAluResult == 32'd0);
    assign bus1.iAluResult = alu_f(bus1.oAluOp, bus1.oAluA, bus1.oAluB);
    assign bus1.iAluZero   = (bus1.iAluResult == 32'd0);

    int errors = 0;
    int checks = 0;
    logic [3:0] op_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b, input bit ee);
        int l, m;
        l = 1;
        m = -1;
        if (ee) begin
            for (int i = 0; i < 32; i++) if (b[i]) m = i;
            for (int i = 0; i <= m; i++) l += 2 + int'(b[i]);
        end else begin
            l = 65;
            for (int i = 0; i < 32; i++) l += int'(b[i]);
        end
        return l;
    endfunction

    // Issue one request; returns at the falling edge of the first cycle with oValid high.
    task automatic do_mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int n;
        @(negedge clk);
        if (sel) begin bus1.iValid = 1'b1; bus1.iDataA = a; bus1.iDataB = b; end
        else     begin bus0.iValid = 1'b1; bus0.iDataA = a; bus0.iDataB = b; end
        n = 0;
        while (!(sel ? bus1.oReady : bus0.oReady) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus0.iValid = 1'b0;
        bus1.iValid = 1'b0;
        op_log.delete();
        lat = 0;
        res = 32'd0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (sel ? bus1.oAluReq : bus0.oAluReq) op_log.push_back(sel ? bus1.oAluOp : bus0.oAluOp);
            if (sel ? bus1.oValid : bus0.oValid) begin
                res = sel ? bus1.oResult : bus0.oResult;
                break;
            end
        end
        if (lat >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout: no oValid within %0d cycles (A=%h B=%h)", lat, a, b);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] r, ra, rb;
    int          l;
    logic [3:0]  exp_ops[8];

    initial begin
        vecs[0] = '{32'd3,         32'd5,         32'd15,        9};
        vecs[1] = '{32'hDEADBEEF,  32'd0,         32'd0,         1};
        vecs[2] = '{32'hDEADBEEF,  32'd1,         32'hDEADBEEF,  4};
        vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  97};
        vecs[4] = '{32'd100,       32'd200,       32'd20000,     20};
        vecs[5] = '{32'h00010000,  32'h00010000,  32'd0,         36};
        vecs[6] = '{32'd3,         32'h80000000,  32'h80000000,  66};
        vecs[7] = '{32'd7,         32'd6,         32'd42,        9};
        exp_ops = '{4'b0000, 4'b0001, 4'b1001, 4'b0001, 4'b1001, 4'b0000, 4'b0001, 4'b1001};

        rst = 1'b1;
        bus0.iValid = 1'b0; bus0.iDataA = 32'd0; bus0.iDataB = 32'd0; bus0.iReady = 1'b1;
        bus1.iValid = 1'b0; bus1.iDataA = 32'd0; bus1.iDataB = 32'd0; bus1.iReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",   {31'd0, bus0.oReady},   32'd1);
        chk("rst_valid",   {31'd0, bus0.oValid},   32'd0);
        chk("rst_busy",    {31'd0, bus0.oBusy},    32'd0);
        chk("rst_alureq",  {31'd0, bus0.oAluReq},  32'd0);
        chk("rst_alua",    bus0.oAluA,             32'd0);
        chk("rst_alub",    bus0.oAluB,             32'd0);
        chk("rst_aluop",   {28'd0, bus0.oAluOp},   32'd0);
        chk("rst_result",  bus0.oResult,           32'd0);

        // Micro-op sequence for 3*5
        do_mul(1'b0, 32'd3, 32'd5, r, l);
        chk("seq_result", r, 32'd15);
        chk("seq_lat", l, 32'd9);
        chk("seq_len", op_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < op_log.size()) chk($sformatf("seq_op%0d", i), {28'd0, op_log[i]}, {28'd0, exp_ops[i]});
        end

        for (int i = 0; i < 8; i++) begin
            do_mul(1'b0, vecs[i].a, vecs[i].b, r, l);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_lat", i), l, vecs[i].lat);
        end

        // Back-pressure: result held in DONE while the consumer stalls
        bus0.iReady = 1'b0;
        do_mul(1'b0, 32'd7, 32'd6, r, l);
        chk("bp_first", r, 32'd42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_result", i), bus0.oResult, 32'd42);
            chk($sformatf("bp%0d_valid", i), {31'd0, bus0.oValid}, 32'd1);
            chk($sformatf("bp%0d_ready", i), {31'd0, bus0.oReady}, 32'd0);
            chk($sformatf("bp%0d_alureq", i), {31'd0, bus0.oAluReq}, 32'd0);
        end
        bus0.iReady = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", {31'd0, bus0.oReady}, 32'd1);
        chk("bp_rel_valid", {31'd0, bus0.oValid}, 32'd0);
        chk("bp_rel_busy",  {31'd0, bus0.oBusy},  32'd0);

        // Reset mid-operation
        @(negedge clk);
        bus0.iValid = 1'b1; bus0.iDataA = 32'd100; bus0.iDataB = 32'd200;
        @(posedge clk);
        #1 bus0.iValid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", {31'd0, bus0.oBusy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_busy",   {31'd0, bus0.oBusy},   32'd0);
        chk("mid_valid",  {31'd0, bus0.oValid},  32'd0);
        chk("mid_alureq", {31'd0, bus0.oAluReq}, 32'd0);
        chk("mid_ready",  {31'd0, bus0.oReady},  32'd1);
        do_mul(1'b0, 32'd100, 32'd200, r, l);
        chk("mid_redo_result", r, 32'd20000);

        // Fixed 32-iteration variant
        do_mul(1'b1, 32'd5, 32'd2, r, l);
        chk("ee0_result", r, 32'd10);
        chk("ee0_lat", l, 32'd66);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            do_mul(1'b0, ra, rb, r, l);
            chk($sformatf("rnd%0d_result", i), r, ra * rb);
            chk($sformatf("rnd%0d_lat", i), l, exp_lat(rb, 1'b1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
